// File: rtl/multiply.sv
// Sequential shift-add multiply-accumulate: product = multiplicand * multiplier + addend.
// Start/busy/done handshake with a fixed latency of WIDTH+1 cycles from the start edge to done.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | one multiplier bit per cycle, LSB first, WIDTH cycles
// DONE  | done pulse; product valid; a new start is accepted here as in IDLE
module multiply #(
   parameter int WIDTH = 3
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [WIDTH-1:0]   multiplicand,
   input  logic [WIDTH-1:0]   multiplier,
   input  logic [WIDTH-1:0]   addend,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] product,
   output logic               rem_invalid
);

   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t             state;
   logic [2*WIDTH-1:0] acc;
   logic [2*WIDTH-1:0] acc_next;
   logic [2*WIDTH-1:0] mcand_sh;
   logic [WIDTH-1:0]   mplier_sh;
   logic [CW-1:0]      count;
   logic               rem_flag;

   // The 2W-bit sum cannot overflow: the worst case is 2^2W - 2^W.
   always_comb begin
      acc_next = acc;
      if (mplier_sh[0])
         acc_next = acc + mcand_sh;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         acc         <= '0;
         mcand_sh    <= '0;
         mplier_sh   <= '0;
         count       <= '0;
         rem_flag    <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         product     <= '0;
         rem_invalid <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               done <= 1'b0;
               if (start) begin
                  acc       <= {{WIDTH{1'b0}}, addend};
                  mcand_sh  <= {{WIDTH{1'b0}}, multiplicand};
                  mplier_sh <= multiplier;
                  count     <= '0;
                  rem_flag  <= (addend >= multiplier);
                  busy      <= 1'b1;
                  state     <= RUN;
               end else begin
                  state <= IDLE;
               end
            end
            RUN: begin
               acc       <= acc_next;
               mcand_sh  <= mcand_sh << 1;
               mplier_sh <= mplier_sh >> 1;
               count     <= count + 1'b1;
               // Flag is published together with the product so both stay coherent until the next result.
               if (count == LAST) begin
                  product     <= acc_next;
                  rem_invalid <= rem_flag;
                  busy        <= 1'b0;
                  done        <= 1'b1;
                  state       <= DONE;
               end
            end
            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_multiply.sv
// Self-checking bench for multiply: directed scenarios plus a randomized full sweep
// and a divide round-trip, all checked against plain arithmetic.
module tb_multiply;

   localparam int W = 3;

   logic           clk;
   logic           rst_n;
   logic           start;
   logic [W-1:0]   multiplicand;
   logic [W-1:0]   multiplier;
   logic [W-1:0]   addend;
   logic           busy;
   logic           done;
   logic [2*W-1:0] product;
   logic           rem_invalid;

   int ntotal;
   int nbad;
   int overlap;

   multiply #(.WIDTH(W)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .multiplicand (multiplicand),
      .multiplier   (multiplier),
      .addend       (addend),
      .busy         (busy),
      .done         (done),
      .product      (product),
      .rem_invalid  (rem_invalid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Samples at successive negedges until done; inputs are scrambled meanwhile (start held low).
   task automatic wait_done(output int nbusy, output bit got);
      nbusy = 0;
      got   = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (busy && done) overlap++;
         if (done) begin
            got = 1'b1;
            break;
         end
         if (busy) nbusy++;
         multiplicand = W'($urandom);
         multiplier   = W'($urandom);
         addend       = W'($urandom);
         @(negedge clk);
      end
   endtask

   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c,
                         output int nbusy, output bit got);
      @(negedge clk);
      multiplicand = a;
      multiplier   = b;
      addend       = c;
      start        = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(nbusy, got);
   endtask

   function automatic int ref_prod(input int a, input int b, input int c);
      return a * b + c;
   endfunction

   task automatic test_reset();
      rst_n = 1'b0;
      start = 1'b0;
      multiplicand = '0;
      multiplier   = '0;
      addend       = '0;
      repeat (3) @(negedge clk);
      ntotal++;
      if (busy !== 1'b0 || done !== 1'b0 || product !== '0 || rem_invalid !== 1'b0) begin
         nbad++;
         $display("FAIL reset: busy=%b done=%b product=%0d rem_invalid=%b, need all 0",
                  busy, done, product, rem_invalid);
      end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_basic();
      int nb;
      bit got;
      run_op(3'd3, 3'd2, 3'd1, nb, got);
      ntotal++;
      if (!got || nb !== W) begin
         nbad++;
         $display("FAIL basic_latency: got_done=%b busy_cycles=%0d, need 1 and %0d", got, nb, W);
      end
      ntotal++;
      if (product !== 6'd7 || rem_invalid !== 1'b0) begin
         nbad++;
         $display("FAIL basic_result: product=%0d rem_invalid=%b, need 7 and 0", product, rem_invalid);
      end
      @(negedge clk);
      ntotal++;
      if (done !== 1'b0 || busy !== 1'b0 || product !== 6'd7) begin
         nbad++;
         $display("FAIL basic_hold: done=%b busy=%b product=%0d, need 0 0 7", done, busy, product);
      end
   endtask

   task automatic test_rem_flag();
      int nb;
      bit got;
      run_op(3'd7, 3'd7, 3'd6, nb, got);
      ntotal++;
      if (!got || product !== 6'd55 || rem_invalid !== 1'b0) begin
         nbad++;
         $display("FAIL max_valid: done=%b product=%0d rem_invalid=%b, need 1 55 0", got, product, rem_invalid);
      end
      run_op(3'd7, 3'd7, 3'd7, nb, got);
      ntotal++;
      if (!got || product !== 6'd56 || rem_invalid !== 1'b1) begin
         nbad++;
         $display("FAIL max_invalid: done=%b product=%0d rem_invalid=%b, need 1 56 1", got, product, rem_invalid);
      end
   endtask

   task automatic test_zero();
      int nb;
      bit got;
      run_op(3'd0, 3'd5, 3'd4, nb, got);
      ntotal++;
      if (!got || nb !== W || product !== 6'd4 || rem_invalid !== 1'b0) begin
         nbad++;
         $display("FAIL zero_mcand: done=%b busy_cycles=%0d product=%0d rem_invalid=%b, need 1 %0d 4 0",
                  got, nb, product, rem_invalid, W);
      end
      run_op(3'd2, 3'd0, 3'd0, nb, got);
      ntotal++;
      if (!got || nb !== W || product !== 6'd0 || rem_invalid !== 1'b1) begin
         nbad++;
         $display("FAIL zero_mplier: done=%b busy_cycles=%0d product=%0d rem_invalid=%b, need 1 %0d 0 1",
                  got, nb, product, rem_invalid, W);
      end
   endtask

   task automatic test_back_to_back();
      int nb;
      bit got;
      @(negedge clk);
      multiplicand = 3'd3;
      multiplier   = 3'd3;
      addend       = 3'd0;
      start        = 1'b1;
      @(negedge clk);
      multiplicand = 3'd1;
      multiplier   = 3'd1;
      addend       = 3'd1;
      @(negedge clk);
      start = 1'b0;
      wait_done(nb, got);
      ntotal++;
      if (!got || nb !== W - 1 || product !== 6'd9 || rem_invalid !== 1'b0) begin
         nbad++;
         $display("FAIL start_in_run: done=%b busy_left=%0d product=%0d rem_invalid=%b, need 1 %0d 9 0",
                  got, nb, product, rem_invalid, W - 1);
      end
      multiplicand = 3'd1;
      multiplier   = 3'd1;
      addend       = 3'd1;
      start        = 1'b1;
      @(negedge clk);
      start = 1'b0;
      ntotal++;
      if (busy !== 1'b1 || done !== 1'b0) begin
         nbad++;
         $display("FAIL b2b_accept: busy=%b done=%b, need 1 0", busy, done);
      end
      wait_done(nb, got);
      ntotal++;
      if (!got || nb !== W || product !== 6'd2 || rem_invalid !== 1'b1) begin
         nbad++;
         $display("FAIL b2b_result: done=%b busy_cycles=%0d product=%0d rem_invalid=%b, need 1 %0d 2 1",
                  got, nb, product, rem_invalid, W);
      end
   endtask

   task automatic test_async_reset();
      int nb;
      bit got;
      int seen;
      @(negedge clk);
      multiplicand = 3'd5;
      multiplier   = 3'd6;
      addend       = 3'd2;
      start        = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      ntotal++;
      if (busy !== 1'b0 || done !== 1'b0 || product !== '0 || rem_invalid !== 1'b0) begin
         nbad++;
         $display("FAIL async_reset: busy=%b done=%b product=%0d rem_invalid=%b, need all 0",
                  busy, done, product, rem_invalid);
      end
      @(negedge clk);
      #2 rst_n = 1'b1;
      seen = 0;
      repeat (8) begin
         @(negedge clk);
         if (done || busy) seen++;
      end
      ntotal++;
      if (seen !== 0) begin
         nbad++;
         $display("FAIL post_reset_idle: activity_cycles=%0d, need 0", seen);
      end
      run_op(3'd5, 3'd6, 3'd2, nb, got);
      ntotal++;
      if (!got || nb !== W || product !== 6'd32 || rem_invalid !== 1'b0) begin
         nbad++;
         $display("FAIL post_reset_op: done=%b busy_cycles=%0d product=%0d rem_invalid=%b, need 1 %0d 32 0",
                  got, nb, product, rem_invalid, W);
      end
   endtask

   task automatic test_sweep();
      int order[512];
      int nb;
      bit got;
      int a, b, c, exp_p;
      bit exp_r;
      for (int i = 0; i < 512; i++) order[i] = i;
      for (int i = 511; i > 0; i--) begin
         int j, t;
         j = int'($urandom_range(i, 0));
         t = order[i];
         order[i] = order[j];
         order[j] = t;
      end
      for (int i = 0; i < 512; i++) begin
         a = order[i] / 64;
         b = (order[i] / 8) % 8;
         c = order[i] % 8;
         exp_p = ref_prod(a, b, c);
         exp_r = (c >= b);
         run_op(W'(a), W'(b), W'(c), nb, got);
         ntotal++;
         if (!got || nb !== W || product !== 6'(exp_p) || rem_invalid !== exp_r) begin
            nbad++;
            $display("FAIL sweep %0d*%0d+%0d: done=%b busy_cycles=%0d product=%0d rem_invalid=%b, need 1 %0d %0d %b",
                     a, b, c, got, nb, product, rem_invalid, W, exp_p, exp_r);
         end
      end
      ntotal++;
      if (overlap !== 0) begin
         nbad++;
         $display("FAIL busy_done_overlap: cycles=%0d, need 0", overlap);
      end
   endtask

   task automatic test_roundtrip();
      int nb;
      bit got;
      int q, r;
      for (int d = 0; d < 8; d++) begin
         for (int v = 1; v < 8; v++) begin
            q = d / v;
            r = d % v;
            run_op(W'(q), W'(v), W'(r), nb, got);
            ntotal++;
            if (!got || product !== 6'(d) || rem_invalid !== 1'b0) begin
               nbad++;
               $display("FAIL roundtrip %0d/%0d: done=%b product=%0d rem_invalid=%b, need 1 %0d 0",
                        d, v, got, product, rem_invalid, d);
            end
         end
      end
   endtask

   initial begin
      ntotal  = 0;
      nbad    = 0;
      overlap = 0;
      test_reset();
      test_basic();
      test_rem_flag();
      test_zero();
      test_back_to_back();
      test_async_reset();
      test_sweep();
      test_roundtrip();
      $display("test done: total=%0d bad=%0d", ntotal, nbad);
      $finish;
   end

endmodule

// File: doc/multiply.md
Name: multiply

Overview:
Sequential shift-add multiply-accumulate unit, the inverse of the team's divider: reconstructs dividend = quotient * divisor + remainder. Sits beside `divide` in the simple processor datapath and serves two purposes. It is the MUL-class execution unit, and verification uses it as a round-trip checker for divider results. It uses a start/busy/done handshake and has a fixed latency of WIDTH+1 cycles from the start edge to done.

Parameters:
WIDTH, 3, operand width in bits; product is 2*WIDTH bits.

Ports:
clk  input  1  system clock, rising-edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  request; sampled on rising clk when accepting (IDLE or DONE state).
multiplicand  input  WIDTH  quotient operand; captured on accepted start.
multiplier  input  WIDTH  divisor operand; captured on accepted start.
addend  input  WIDTH  remainder operand; captured on accepted start, zero-extended.
busy  output  1  high while in RUN state.
done  output  1  single-cycle pulse; product valid from this cycle.
product  output  2*WIDTH  multiplicand*multiplier + addend; held until next accepted start.
rem_invalid  output  1  registered flag = (addend >= multiplier) for the captured operands; valid with done, held with product.

Behaviour:
- Reset (rst_n low, asynchronous, any state):
  - state=IDLE; busy=0, done=0, product=0, rem_invalid=0.
  - All internal operand, accumulator and count registers cleared.
  - An in-flight operation is discarded.
  - Operation resumes on the first rising clk after rst_n rises.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 at edge k → capture operands, acc = zero-extended addend.
  - mcand_sh = zero-extended multiplicand; mplier_sh = multiplier; count=0.
  - rem_invalid computed from captured values; state→RUN.
  - start=0 → stay in IDLE.
- RUN, one multiplier bit per cycle, LSB first:
  - If mplier_sh[0]=1: acc += mcand_sh, computed at 2*WIDTH bits with no truncation.
  - Then mcand_sh <<= 1, mplier_sh >>= 1, count++.
  - After WIDTH RUN cycles (edge k+WIDTH), product ← acc and state→DONE.
  - No early exit: a zero or small multiplier still takes exactly WIDTH cycles.
  - start is ignored in RUN; operand inputs may change freely with no effect.
- DONE:
  - done=1 for exactly one cycle (cycle after edge k+WIDTH).
  - start=1 in DONE is accepted exactly as in IDLE (back-to-back, state→RUN); otherwise state→IDLE.
- busy: 1 for cycles k+1 .. k+WIDTH (WIDTH cycles); 0 in IDLE and DONE.
- done and busy are never high together.
- Width rule: the maximum result (2^W-1)^2 + (2^W-1) = 2^2W - 2^W fits 2W bits, so no overflow output is needed.
- product changes only on the transition into DONE, and on reset.

Test Plan:
- Reset then start with multiplicand=3, multiplier=2, addend=1 (divide round-trip for 7/2) → busy high 3 cycles, then done pulse 1 cycle, product=7, rem_invalid=0; done falls the next cycle while product stays 7.
- Start with 7, 7, 6 → product=55, rem_invalid=0; then start with 7, 7, 7 → product=56, rem_invalid=1.
- Start with 0, 5, 4 → still exactly 3 busy cycles, product=4; then start with 2, 0, 0 → product=0, rem_invalid=1 (divide-by-zero case flagged).
- Start with 3, 3, 0; during busy, pulse start with 1, 1, 1 → second request ignored, product=9. Then assert start with 1, 1, 1 in the done cycle → accepted, next done gives product=2.
- Start with 5, 6, 2; drop rst_n mid-RUN (second busy cycle, asynchronously between edges) → busy, done and product go to 0 immediately. After release, no done appears until a new start. New start with 5, 6, 2 → product=32.
- Randomised sweep of all 512 operand combinations, each checked against a reference model. Additionally, feed every (dividend, divisor≠0) pair through `divide`, and its quotient and remainder through this block → product equals dividend and rem_invalid=0.
